// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//   Receives a boot image as a byte stream over a valid/ready link and writes
//   it into the instruction memory. The core is held in reset until the image
//   has loaded. Each byte is taken when rx_valid and rx_ready are both high.
//   The stream is a 16-bit little-endian word count followed by the data bytes.
//   Four data bytes make one little-endian word, and each word takes a single
//   write cycle.
//
//   Optional feature: define IMEM_BOOT_CHECKSUM_EN to add a trailing checksum
//   byte. The checksum is the modulo-256 sum of all data bytes, and a mismatch
//   ends the load in the error state.
//
// Ports
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   start        : one-cycle pulse that begins a load; ignored while busy
//   rx_data      : incoming byte
//   rx_valid     : rx_data is valid
//   rx_ready     : loader accepts a byte this cycle
//   mem_we       : one-cycle instruction memory write strobe
//   mem_addr     : word-aligned byte address of the write
//   mem_wdata    : assembled instruction word
//   core_rst_n   : active-low core reset, released only after a good load
//   busy         : load in progress
//   done         : last load completed successfully
//   err          : last load aborted
// -----------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             core_rst_n,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_LOAD, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_e;

  // Largest image the memory can hold, in words.
  localparam logic [16:0] MAX_WORDS = 17'(1) << DEPTH;

  // State entered once the last word has been written (or the image is empty).
`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam state_e S_FINISH = S_CSUM;
`else
  localparam state_e S_FINISH = S_DONE;
`endif

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] idx_q,   idx_d;
  logic [1:0]  bidx_q,  bidx_d;
  logic [31:0] word_q,  word_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0]  sum_q,   sum_d;
`endif

  logic             rx_ready_q,   rx_ready_d;
  logic             mem_we_q,     mem_we_d;
  logic [WIDTH-1:0] mem_addr_q,   mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q,  mem_wdata_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;
  logic             err_q,        err_d;

  logic        accept;
  logic [15:0] hdr_count;

  // rx_ready_q mirrors the current state, so it gates the handshake directly.
  assign accept    = rx_valid && rx_ready_q;
  assign hdr_count = {rx_data, count_q[7:0]};

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      bidx_q  <= '0;
      word_q  <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case statement, so no
    // path through the block leaves one unassigned and no latch is inferred.
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR0;
          count_d = '0;
          idx_d   = '0;
          bidx_d  = '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_HDR0: begin
        if (accept) begin
          count_d[7:0] = rx_data;
          state_d      = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          count_d = hdr_count;
          if ({1'b0, hdr_count} > MAX_WORDS) state_d = S_ERR;
          else if (hdr_count == '0)          state_d = S_FINISH;
          else                               state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          word_d[8*bidx_q +: 8] = rx_data;
          bidx_d = bidx_q + 2'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
          sum_d  = sum_q + rx_data;
`endif
          if (bidx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d   = idx_q + 16'd1;
        state_d = (idx_d == count_q) ? S_FINISH : S_LOAD;
      end
      S_CSUM: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
        if (accept) state_d = (rx_data == sum_q) ? S_DONE : S_ERR;
`else
        state_d = S_DONE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: computed from the next state so outputs are registered yet
  // aligned with the state they describe. The write address uses the index
  // before WRITE increments it.
  // --------------------------------------------------------------------------
  always_comb begin
    rx_ready_d   = state_d inside {S_HDR0, S_HDR1, S_LOAD, S_CSUM};
    busy_d       = state_d inside {S_HDR0, S_HDR1, S_LOAD, S_WRITE, S_CSUM};
    mem_we_d     = (state_d == S_WRITE);
    done_d       = (state_d == S_DONE);
    err_d        = (state_d == S_ERR);
    core_rst_n_d = (state_d == S_DONE);
    mem_addr_d   = mem_we_d ? WIDTH'({idx_q, 2'b00}) : '0;
    mem_wdata_d  = mem_we_d ? WIDTH'(word_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rx_ready_q   <= rx_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
//   Self-checking bench for imem_boot_loader. A table of image vectors is sent
//   with and without idle gaps, and each vector's status and writes are
//   checked. Hand-written sequences then cover the boundary count and a reset
//   that arrives in the middle of a load. Define IMEM_BOOT_CHECKSUM_EN for both
//   the bench and the RTL to exercise the checksum build.
// -----------------------------------------------------------------------------
module tb_imem_boot_loader;

`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam int CS = 1;
  // Basic image with its checksum appended. The checksum is the modulo-256 sum
  // 13+01+50+00+93+01+C0+00 = 0x1B8, giving 0xB8.
  localparam logic [95:0] BASIC   = {88'h0200_1301_5000_9301_C000_B8, 8'h0};
  localparam logic [95:0] BAD_CS  = {88'h0200_1301_5000_9301_C000_B9, 8'h0};
  // The one-word image sums to EF+BE+AD+DE = 0x338, giving a checksum of 0x38.
  localparam logic [95:0] ONEWORD = {56'h0100_EFBE_ADDE_38, 40'h0};
`else
  localparam int CS = 0;
  localparam logic [95:0] BASIC   = {80'h0200_1301_5000_9301_C000, 16'h0};
  localparam logic [95:0] BAD_CS  = '0;
  localparam logic [95:0] ONEWORD = {48'h0100_EFBE_ADDE, 48'h0};
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, mem_we, core_rst_n, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;

  imem_boot_loader #(.WIDTH(32), .DEPTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Write monitor: records every strobe, sampled on the falling edge.
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      check("ready_low_during_write", 32'(rx_ready), 32'd0);
    end
  end

  typedef struct {
    logic [95:0] bytes;        // stream, first byte in bits [95:88]
    int          nbytes;
    bit          rand_gap;
    bit          restart_mid;  // pulse start after the first byte
    int          exp_writes;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
    bit          exp_done;     // 1 -> done, 0 -> err
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    if (!ok) check("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    time t0;
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    t0 = $time;
    check($sformatf("v%0d_start_status", id), 32'({busy, core_rst_n, done, err, rx_ready}), 32'b10001);
    for (int i = 0; i < v.nbytes; i++) begin
      send_byte(v.bytes[95-8*i -: 8]);
      if (v.restart_mid && i == 0) pulse_start();
      if (v.rand_gap) repeat ($urandom_range(0, 3)) step();
    end
    if (v.exp_writes == 0 && v.exp_done)
      check($sformatf("v%0d_done_immediate", id), 32'(done), 32'd1);
    for (int n = 0; n < 20; n++) begin
      if (!busy) break;
      step();
    end
    check($sformatf("v%0d_busy_timeout", id), 32'(busy), 32'd0);
    if (!v.rand_gap && !v.restart_mid && v.exp_done)
      check($sformatf("v%0d_cycles", id), 32'((($time - t0) / 10)), 32'(2 + 5 * v.exp_writes + CS));
    check($sformatf("v%0d_final_status", id),
          32'({busy, done, err, core_rst_n, rx_ready}),
          32'({1'b0, v.exp_done, !v.exp_done, v.exp_done, 1'b0}));
    check($sformatf("v%0d_write_count", id), 32'(wr_addr.size()), 32'(v.exp_writes));
    for (int w = 0; w < v.exp_writes; w++) begin
      if (w < wr_addr.size()) begin
        check($sformatf("v%0d_addr%0d", id, w), wr_addr[w], 32'(4 * w));
        check($sformatf("v%0d_data%0d", id, w), wr_data[w], (w == 0) ? v.exp_w0 : v.exp_w1);
      end
    end
  endtask

  initial begin
    vec_t vecs[$];
    vecs.push_back('{bytes: BASIC, nbytes: 10 + CS, rand_gap: 0, restart_mid: 0, exp_writes: 2,
                     exp_w0: 32'h0050_0113, exp_w1: 32'h00C0_0193, exp_done: 1});
    vecs.push_back('{bytes: BASIC, nbytes: 10 + CS, rand_gap: 1, restart_mid: 0, exp_writes: 2,
                     exp_w0: 32'h0050_0113, exp_w1: 32'h00C0_0193, exp_done: 1});
    vecs.push_back('{bytes: BASIC, nbytes: 10 + CS, rand_gap: 0, restart_mid: 1, exp_writes: 2,
                     exp_w0: 32'h0050_0113, exp_w1: 32'h00C0_0193, exp_done: 1});
    vecs.push_back('{bytes: 96'h0, nbytes: 2 + CS, rand_gap: 0, restart_mid: 0, exp_writes: 0,
                     exp_w0: 32'h0, exp_w1: 32'h0, exp_done: 1});
    vecs.push_back('{bytes: {16'h0101, 80'h0}, nbytes: 2, rand_gap: 0, restart_mid: 0, exp_writes: 0,
                     exp_w0: 32'h0, exp_w1: 32'h0, exp_done: 0});
    vecs.push_back('{bytes: ONEWORD, nbytes: 6 + CS, rand_gap: 1, restart_mid: 0, exp_writes: 1,
                     exp_w0: 32'hDEAD_BEEF, exp_w1: 32'h0, exp_done: 1});
    if (CS != 0)
      vecs.push_back('{bytes: BAD_CS, nbytes: 11, rand_gap: 0, restart_mid: 0, exp_writes: 2,
                       exp_w0: 32'h0050_0113, exp_w1: 32'h00C0_0193, exp_done: 0});

    // Reset state.
    #2;
    check("reset_ctrl", 32'({rx_ready, mem_we, core_rst_n, busy, done, err}), 32'd0);
    check("reset_addr", mem_addr, 32'd0);
    check("reset_wdata", mem_wdata, 32'd0);
    #10 rst_n = 1'b1;
    step();
    check("idle_ctrl", 32'({rx_ready, mem_we, core_rst_n, busy, done, err}), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // A count of exactly 2**DEPTH words is legal: the loader moves on to data.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    check("max_count_accepted", 32'({busy, err, rx_ready}), 32'b101);

    // Reset in the middle of a load, with the fourth data byte on the link.
    wr_addr.delete();
    wr_data.delete();
    #2 rst_n = 1'b0;
    #1;
    check("midload0_reset_ctrl", 32'({rx_ready, mem_we, core_rst_n, busy, done, err}), 32'd0);
    #2 rst_n = 1'b1;
    step();
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(BASIC[95-8*i -: 8]);
    rx_data  = 8'h01;
    rx_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midload_reset_ctrl", 32'({rx_ready, mem_we, core_rst_n, busy, done, err}), 32'd0);
    check("midload_reset_addr", mem_addr, 32'd0);
    check("midload_reset_wdata", mem_wdata, 32'd0);
    repeat (3) step();
    check("midload_no_write", 32'(wr_addr.size()), 32'd0);
    rx_valid = 1'b0;
    #2 rst_n = 1'b1;
    step();
    run_vec(vecs[0], 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
